// File: rtl/cpu.sv
// Multicycle 16-bit CPU: IR, 8x16 register file, B-side shifter, ALU, A/B/C registers
// and N/V/Z status, sequenced by a seven-state controller.
module cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        N,
    output logic        V,
    output logic        Z,
    output logic        w
);

    typedef enum logic [2:0] {
        ST_WAIT     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_GETA     = 3'd2,
        ST_GETB     = 3'd3,
        ST_COMPUTE  = 3'd4,
        ST_WRITEREG = 3'd5,
        ST_WRITEIMM = 3'd6
    } state_t;

    function automatic logic [15:0] shift_f(input logic [15:0] v, input logic [1:0] sh);
        logic [15:0] r;
        case (sh)
            2'b00:   r = v;
            2'b01:   r = {v[14:0], 1'b0};
            2'b10:   r = {1'b0, v[15:1]};
            2'b11:   r = {v[15], v[15:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Returns {N, V, Z, result}; V reflects the add or subtract actually performed.
    function automatic logic [18:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
        logic [15:0] r;
        logic        vf;
        r  = 16'h0000;
        vf = 1'b0;
        case (op)
            2'b00: begin
                r  = a + b;
                vf = (a[15] == b[15]) && (r[15] != a[15]);
            end
            2'b01: begin
                r  = a - b;
                vf = (a[15] != b[15]) && (r[15] != a[15]);
            end
            2'b10:   r = a & b;
            2'b11:   r = ~b;
            default: r = 16'h0000;
        endcase
        return {r[15], vf, (r == 16'h0000), r};
    endfunction

    state_t      state_q, state_d;
    logic        w_q, w_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] c_q, c_d;
    logic        n_q, n_d;
    logic        v_q, v_d;
    logic        z_q, z_d;
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];

    logic [2:0]  opcode_s;
    logic [1:0]  op_s;
    logic [2:0]  rn_s, rd_s, rm_s;
    logic [1:0]  sh_s;
    logic [15:0] sximm8_s;
    logic        is_movimm_s, is_movreg_s, is_alu_s, is_cmp_s;

    logic        load_a_s, load_b_s, load_c_s, load_st_s, zero_a_s;
    logic        write_en_s, write_imm_s;
    logic [2:0]  waddr_s;
    logic [15:0] wdata_s;
    logic [15:0] alu_a_s, alu_b_s;
    logic [1:0]  alu_op_s;
    logic [18:0] alu_res_s;

    // Instruction field decode from IR
    always_comb begin
        opcode_s    = ir_q[15:13];
        op_s        = ir_q[12:11];
        rn_s        = ir_q[10:8];
        rd_s        = ir_q[7:5];
        sh_s        = ir_q[4:3];
        rm_s        = ir_q[2:0];
        sximm8_s    = {{8{ir_q[7]}}, ir_q[7:0]};
        is_movimm_s = (opcode_s == 3'b110) && (op_s == 2'b10);
        is_movreg_s = (opcode_s == 3'b110) && (op_s == 2'b00);
        is_alu_s    = (opcode_s == 3'b101);
        is_cmp_s    = is_alu_s && (op_s == 2'b01);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_WAIT;
            w_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: begin
                if (s) state_d = ST_DECODE;
                else   state_d = ST_WAIT;
            end
            ST_DECODE: begin
                if (is_movimm_s)      state_d = ST_WRITEIMM;
                else if (is_movreg_s) state_d = ST_GETB;
                else if (is_alu_s)    state_d = ST_GETA;
                else                  state_d = ST_WAIT;
            end
            ST_GETA:    state_d = ST_GETB;
            ST_GETB:    state_d = ST_COMPUTE;
            ST_COMPUTE: begin
                if (is_cmp_s) state_d = ST_WAIT;
                else          state_d = ST_WRITEREG;
            end
            ST_WRITEREG: state_d = ST_WAIT;
            ST_WRITEIMM: state_d = ST_WAIT;
            default:     state_d = ST_WAIT;
        endcase
        w_d = (state_d == ST_WAIT);
    end

    // FSM output (datapath control) logic
    always_comb begin
        load_a_s    = 1'b0;
        load_b_s    = 1'b0;
        load_c_s    = 1'b0;
        load_st_s   = 1'b0;
        zero_a_s    = 1'b0;
        write_en_s  = 1'b0;
        write_imm_s = 1'b0;
        case (state_q)
            ST_GETA: load_a_s = 1'b1;
            ST_GETB: load_b_s = 1'b1;
            ST_COMPUTE: begin
                load_c_s  = 1'b1;
                load_st_s = is_cmp_s;
                zero_a_s  = is_movreg_s;
            end
            ST_WRITEREG: write_en_s = 1'b1;
            ST_WRITEIMM: begin
                write_en_s  = 1'b1;
                write_imm_s = 1'b1;
            end
            default: begin
                load_a_s   = 1'b0;
                write_en_s = 1'b0;
            end
        endcase
    end

    // Datapath next-state: IR, operand registers, ALU, status and register file
    always_comb begin
        ir_d      = load ? in : ir_q;
        a_d       = load_a_s ? regs_q[rn_s] : a_q;
        b_d       = load_b_s ? regs_q[rm_s] : b_q;
        alu_a_s   = zero_a_s ? 16'h0000 : a_q;
        alu_b_s   = shift_f(b_q, sh_s);
        alu_op_s  = is_movreg_s ? 2'b00 : op_s;
        alu_res_s = alu_f(alu_a_s, alu_b_s, alu_op_s);
        c_d       = load_c_s ? alu_res_s[15:0] : c_q;
        if (load_st_s) begin
            n_d = alu_res_s[18];
            v_d = alu_res_s[17];
            z_d = alu_res_s[16];
        end else begin
            n_d = n_q;
            v_d = v_q;
            z_d = z_q;
        end
        waddr_s = write_imm_s ? rn_s : rd_s;
        wdata_s = write_imm_s ? sximm8_s : c_q;
        regs_d  = regs_q;
        if (write_en_s) begin
            regs_d[waddr_s] = wdata_s;
        end else begin
            regs_d = regs_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            ir_q <= 16'h0000;
            a_q  <= 16'h0000;
            b_q  <= 16'h0000;
            c_q  <= 16'h0000;
            n_q  <= 1'b0;
            v_q  <= 1'b0;
            z_q  <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
        end else begin
            ir_q <= ir_d;
            a_q  <= a_d;
            b_q  <= b_d;
            c_q  <= c_d;
            n_q  <= n_d;
            v_q  <= v_d;
            z_q  <= z_d;
            for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign out = c_q;
    assign N   = n_q;
    assign V   = v_q;
    assign Z   = z_q;
    assign w   = w_q;

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: stimulus pushes expected out/flags/latency; a monitor
// pops and compares whenever w rises (instruction done) or an idle probe is raised.
module tb_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s = 1'b0;
    logic        load = 1'b0;
    logic [15:0] in_s = 16'h0000;
    logic [15:0] out;
    logic        n_o, v_o, z_o, w_o;

    typedef struct {
        int          id;
        logic [15:0] out;
        logic        n, v, z;
        int          lat;   // edges WAIT->WAIT; 0 means not checked
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic probe = 1'b0;
    logic mon_en = 1'b0;
    int   vec_id = 0;

    cpu dut (
        .clk  (clk),
        .reset(reset),
        .s    (s),
        .load (load),
        .in   (in_s),
        .out  (out),
        .N    (n_o),
        .V    (v_o),
        .Z    (z_o),
        .w    (w_o)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        logic w_prev;
        int   busy;
        exp_t e;
        w_prev = 1'b1;
        busy   = 0;
        forever begin
            @(negedge clk);
            if (!w_o) busy++;
            if (mon_en && ((w_o && !w_prev) || probe)) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: out=%h with empty scoreboard", out);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (out !== e.out) begin
                        errors++;
                        $display("FAIL out vec%0d: got %h expected %h", e.id, out, e.out);
                    end
                    checks++;
                    if ({n_o, v_o, z_o} !== {e.n, e.v, e.z}) begin
                        errors++;
                        $display("FAIL nvz vec%0d: got %b%b%b expected %b%b%b",
                                 e.id, n_o, v_o, z_o, e.n, e.v, e.z);
                    end
                    checks++;
                    if (w_o !== 1'b1) begin
                        errors++;
                        $display("FAIL w vec%0d: got %b expected 1", e.id, w_o);
                    end
                    if (e.lat > 0) begin
                        checks++;
                        if (busy != e.lat - 1) begin
                            errors++;
                            $display("FAIL latency vec%0d: got %0d expected %0d",
                                     e.id, busy + 1, e.lat);
                        end
                    end
                end
            end
            if (w_o) busy = 0;
            w_prev = w_o;
        end
    end

    task automatic push(input logic [15:0] eo, input logic en, input logic ev,
                        input logic ez, input int lat);
        exp_t e;
        vec_id++;
        e.id = vec_id; e.out = eo; e.n = en; e.v = ev; e.z = ez; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (!w_o && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (!w_o) begin
            checks++; errors++;
            $display("FAIL timeout vec%0d: w still %b after 20 cycles", vec_id, w_o);
            sb.delete();
        end
    endtask

    task automatic run(input logic [15:0] ins, input logic ld, input logic [15:0] eo,
                       input logic en, input logic ev, input logic ez, input int lat);
        @(posedge clk); #1;
        load = ld;
        if (ld) in_s = ins;
        push(eo, en, ev, ez, lat);
        @(posedge clk); #1; s = 1'b1;
        @(posedge clk); #1; s = 1'b0;
        wait_idle();
    endtask

    task automatic idle_check(input logic [15:0] eo, input logic en, input logic ev,
                              input logic ez);
        @(posedge clk); #1;
        push(eo, en, ev, ez, 0);
        probe = 1'b1;
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mon_en = 1'b1;
        idle_check(16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        idle_check(16'h0000, 1'b0, 1'b0, 1'b0);

        run(16'hD004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 3);  // MOV R0,#4
        run(16'hC020, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 5);  // MOV R1,R0
        @(posedge clk); #1; load = 1'b0; in_s = 16'hC048;
        idle_check(16'h0004, 1'b0, 1'b0, 1'b0);
        run(16'hC048, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0, 5);  // IR still MOV R1,R0

        run(16'hD273, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 3);  // MOV R2,#115
        run(16'hA269, 1'b1, 16'h007B, 1'b0, 1'b0, 1'b0, 6);  // ADD R3,R2,R1,LSL#1
        run(16'hB390, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 6);  // AND R4,R3,R0,LSR#1
        run(16'hB8A2, 1'b1, 16'hFF8C, 1'b0, 1'b0, 1'b0, 6);  // MVN R5,R2

        run(16'hA811, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 5);  // CMP R0,R1,LSR#1
        run(16'hA809, 1'b1, 16'hFFFC, 1'b1, 1'b0, 1'b0, 5);  // CMP R0,R1,LSL#1
        run(16'hA801, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 5);  // CMP R0,R1
        run(16'hA269, 1'b1, 16'h007B, 1'b0, 1'b0, 1'b1, 6);  // ADD keeps flags

        run(16'hD2FF, 1'b1, 16'h007B, 1'b0, 1'b0, 1'b1, 3);  // MOV R2,#-1
        run(16'hC0C2, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 5);  // MOV R6,R2
        run(16'hC072, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1, 5);  // MOV R3,R2,LSR#1
        run(16'hAB02, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 5);  // CMP R3,R2 overflows
        run(16'h0000, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 2);  // undefined encoding

        // ADD R3,R2,R1,LSL#1 aborted by reset while in GETB
        @(posedge clk); #1; load = 1'b1; in_s = 16'hA269;
        @(posedge clk); #1; s = 1'b1;
        @(posedge clk); #1; s = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        push(16'h0000, 1'b0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        wait_idle();
        run(16'hC003, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 5);  // MOV R0,R3: R3 cleared

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Multicycle 16-bit CPU: instruction register, 8×16-bit register file, one-bit shifter, ALU, A/B/C pipeline registers, N/V/Z status register.
- A finite-state controller sequences each instruction over several clocks.
- Instructions arrive on `in` from the surrounding test/IO logic.
- Results are visible on `out` (the C register) and the status flags.

Parameters:
- none

Ports:
- clk    input   1   rising-edge clock
- reset  input   1   synchronous active-low reset
- s      input   1   start: begin executing the instruction held in IR
- load   input   1   load `in` into the instruction register
- in     input   16  instruction word
- out    output  16  C register (ALU result)
- N      output  1   status negative
- V      output  1   status signed overflow
- Z      output  1   status zero
- w      output  1   high while the FSM is idle in WAIT

Behaviour:
- All state changes occur on the rising clk edge. Reset has priority over everything.
- **Reset** (reset==0 at an edge):
  - FSM goes to WAIT.
  - IR, A, B, C, R0–R7 and N/V/Z are cleared to 0.
  - Therefore out=0, N=V=Z=0 and w=1 in the following cycle.
- **Instruction register:** when load==1 (not in reset), IR<=in every edge, independent of FSM state. The decoder reads IR combinationally.
- **Field decode:**
  - opcode=IR[15:13], op=IR[12:11]
  - Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0]
  - imm8=IR[7:0], sximm8 = imm8 sign-extended to 16 bits
- **Shifter** (applied to B only):
  - 00 pass
  - 01 LSL by 1, LSB=0
  - 10 LSR by 1, MSB=0
  - 11 ASR by 1, MSB copied
- **Instructions:**
  - 110/10 MOV Rn,#imm8: R[Rn]<=sximm8
  - 110/00 MOV Rd,Rm{,sh}: R[Rd]<=sh(R[Rm])
  - 101/00 ADD Rd,Rn,Rm{,sh}: R[Rd]<=R[Rn]+sh(R[Rm])
  - 101/01 CMP Rn,Rm{,sh}: status<=flags of R[Rn]−sh(R[Rm]); no register write
  - 101/10 AND Rd,Rn,Rm{,sh}: R[Rd]<=R[Rn]&sh(R[Rm])
  - 101/11 MVN Rd,Rm{,sh}: R[Rd]<=~sh(R[Rm])
  - Any other encoding: FSM returns from DECODE to WAIT with no side effects.
- **Arithmetic:** 16-bit two's complement; carry out is discarded.
  - Z = (result==0)
  - N = result[15]
  - V = signed overflow of the add/subtract performed
  - Status register is loaded only in the COMPUTE state of CMP. All other instructions leave N/V/Z unchanged.
- **FSM states:** WAIT, DECODE, GETA, GETB, COMPUTE, WRITEREG, WRITEIMM.
  - WAIT: w=1. Go to DECODE if s==1, else stay.
  - DECODE: MOV imm → WRITEIMM; MOV reg → GETB; ALU ops → GETA.
  - GETA: A<=R[Rn]. → GETB.
  - GETB: B<=R[Rm]. → COMPUTE.
  - COMPUTE: C<=ALU result. For MOV reg the A input is forced to 0 and the operation is ADD. For CMP, C is loaded with the difference and status is updated. CMP → WAIT; all others → WRITEREG.
  - WRITEREG: R[Rd]<=C. → WAIT.
  - WRITEIMM: R[Rn]<=sximm8. → WAIT.
  - w=0 in every state except WAIT.
- **Latency** (edges from WAIT with s=1 back to WAIT):
  - MOV imm: 3
  - MOV reg: 5
  - CMP: 5
  - ADD/AND/MVN: 6
- `out` changes only in COMPUTE.
- If s stays high, the next instruction starts immediately from WAIT, using whatever IR holds at that point.
- Changing `in` mid-instruction with load=1 alters the decode of the remaining states. Callers must hold `in` stable or drop load.
- Reset asserted mid-instruction aborts it at the next edge; no partial writeback occurs after that edge.

Test Plan:
- Reset low 2 clocks, then high, s=0 → out=0, N=V=Z=0, w=1; w stays 1 while s=0.
- s=1, load=1: MOV R0,#4 (0xD004), then MOV R1,R0 (0xC020) → after the MOV reg completes, out=0x0004. Then load=0 with in=0xC048 → R2/out unchanged.
- MOV R2,#115 (0xD273); ADD R3,R2,R1,LSL#1 (0xA269) → out=0x007B. AND R4,R3,R0,LSR#1 (0xB390) → out=0x0002. MVN R5,R2 (0xB8A2) → out=0xFF8C.
- CMP R0,R1,LSR#1 (0xA811) → N=0,Z=0. CMP R0,R1,LSL#1 (0xA809) → N=1. CMP R0,R1 (0xA801) → Z=1,N=0. ADD afterwards leaves flags unchanged.
- MOV R2,#-1 (0xD2FF) → R2=0xFFFF. MOV R3,R2,LSR#1 (0xC072) → out=0x7FFF. CMP R3,R2 (0xAB02) → V=1,N=1,Z=0.
- Start an ADD, assert reset during GETB → next cycle w=1, out=0, destination register 0.
